// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared constants for the up/down sweep sequencer and its counter datapath.
package updown_sweep_ctrl_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int DIV_W_DEF  = 4;
  localparam int PASS_W_DEF = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_RUN_UP = 3'd2;
  localparam logic [2:0] ST_RUN_DN = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DN     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  // The reserved code 11 behaves exactly like an up sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_UP : m;
  endfunction

endpackage

// File: rtl/updown_en_counter.sv
// Up/down counter with synchronous clear and step enable; clear wins over enable.
module updown_en_counter
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // NOTE: every always_comb output is given a default first, so no latch can be inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = up ? q_q + 1'b1 : q_q - 1'b1;
    end
  end

  // No reset: the sequencer always clears the counter before stepping it.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: clears the counter, steps it to a target per pass, and cross-checks
// the counter feedback against an internal shadow count.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  hi,
  input  logic [DIV_W-1:0]  dwell,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
  input  logic [WIDTH-1:0]  ctr_q,
  output logic              ctr_clr,
  output logic              ctr_en,
  output logic              ctr_up,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [DIV_W-1:0]  dwell_q, dwell_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic              ctr_clr_q, ctr_clr_d;
  logic              ctr_en_q, ctr_en_d;
  logic              ctr_up_q, ctr_up_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              chk_q, chk_d;

  logic              end_pass;
  logic              step_due;
  logic [WIDTH-1:0]  pos_up, pos_dn;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    hi_d      = hi_q;
    dwell_d   = dwell_q;
    passes_d  = passes_q;
    timer_d   = timer_q;
    pass_d    = pass_q;
    ctr_clr_d = 1'b0;
    ctr_en_d  = 1'b0;
    done_d    = 1'b0;
    ctr_up_d  = ctr_up_q;
    busy_d    = busy_q;
    end_pass  = 1'b0;
    chk_d     = ctr_en_q | ctr_clr_q;
    err_d     = err_q | (chk_q & (ctr_q != shadow_q));

    // Shadow moves on the same edge the counter sees its clear/step pulse, so step
    // decisions look at shadow_d to account for a pulse still in flight.
    shadow_d = shadow_q;
    if (ctr_clr_q) begin
      shadow_d = '0;
    end else if (ctr_en_q) begin
      shadow_d = ctr_up_q ? shadow_q + 1'b1 : shadow_q - 1'b1;
    end
    pos_up   = shadow_d + 1'b1;
    pos_dn   = shadow_d - 1'b1;
    step_due = (timer_q == dwell_q);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_d   = norm_mode(mode);
          hi_d     = hi;
          dwell_d  = dwell;
          passes_d = passes;
          pass_d   = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_CLR;
        end
      end
      ST_CLR: begin
        ctr_clr_d = 1'b1;
        timer_d   = '0;
        state_d   = (mode_q == MODE_DN) ? ST_RUN_DN : ST_RUN_UP;
      end
      ST_RUN_UP: begin
        if (hi_q == '0) begin
          end_pass = 1'b1;
        end else if (step_due) begin
          ctr_en_d = 1'b1;
          ctr_up_d = 1'b1;
          timer_d  = '0;
          if (pos_up == hi_q) begin
            if (mode_q == MODE_BOUNCE) state_d = ST_RUN_DN;
            else                       end_pass = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RUN_DN: begin
        if (step_due) begin
          ctr_en_d = 1'b1;
          ctr_up_d = 1'b0;
          timer_d  = '0;
          // Bounce returns to zero; a plain down sweep stops hi steps below the wrap point.
          if ((mode_q == MODE_BOUNCE) ? (pos_dn == '0) : (pos_dn == ~hi_q)) end_pass = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_FIN: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        ctr_up_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (end_pass) begin
      if (pass_q == passes_q) begin
        state_d = ST_FIN;
      end else begin
        pass_d  = pass_q + 1'b1;
        state_d = ST_CLR;
      end
    end

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      ctr_en_d  = 1'b0;
      ctr_clr_d = 1'b0;
      ctr_up_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_UP;
      hi_q      <= '0;
      dwell_q   <= '0;
      passes_q  <= '0;
      timer_q   <= '0;
      pass_q    <= '0;
      shadow_q  <= '0;
      ctr_clr_q <= 1'b0;
      ctr_en_q  <= 1'b0;
      ctr_up_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      chk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      hi_q      <= hi_d;
      dwell_q   <= dwell_d;
      passes_q  <= passes_d;
      timer_q   <= timer_d;
      pass_q    <= pass_d;
      shadow_q  <= shadow_d;
      ctr_clr_q <= ctr_clr_d;
      ctr_en_q  <= ctr_en_d;
      ctr_up_q  <= ctr_up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
    end
  end

  assign ctr_clr = ctr_clr_q;
  assign ctr_en  = ctr_en_q;
  assign ctr_up  = ctr_up_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
